// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GAP_CYCLES  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [3:0]  digit_bcd,
    output logic [1:0]  digit_idx,
    output logic        frame_tick,
    output logic        upd_ack
);

    localparam int unsigned CntMax = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ShowLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    typedef enum logic {
        StShow = 1'b0,
        StGap  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     staging_q;
    logic [15:0]     shadow_q, shadow_d;
    logic            pending_q;
    // Holds the scan for one cycle after reset so digit 0 gets its full first SHOW.
    logic            run_q;
    logic [3:0]      an_q, an_d;
    logic [3:0]      bcd_q, bcd_d;
    logic            frame_tick_q;
    logic            upd_ack_q;

    logic            boundary;
    logic            commit;
    logic [3:0]      nib_d;
    logic            nib_ok_d;
    logic            lit_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (run_q) begin
            if (state_q == StShow) begin
                if (cnt_q == ShowLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end else begin
                if (cnt_q == GapLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    assign boundary = run_q && (state_q == StGap) && (cnt_q == GapLast) && (idx_q == 2'd3);
    assign commit   = boundary && (load || pending_q);

    // A load landing on the boundary cycle wins over the older staged frame.
    always_comb begin
        shadow_d = shadow_q;
        if (boundary && load) begin
            shadow_d = digits_in;
        end else if (boundary && pending_q) begin
            shadow_d = staging_q;
        end
    end

    always_comb begin
        case (idx_d)
            2'd0:    nib_d = shadow_d[3:0];
            2'd1:    nib_d = shadow_d[7:4];
            2'd2:    nib_d = shadow_d[11:8];
            default: nib_d = shadow_d[15:12];
        endcase
    end

    assign nib_ok_d = (nib_d <= 4'd9);

`ifdef SEG_SCAN_LZB_EN
    logic zero3, zero32, zero321;
    logic [3:0] blank_d;

    // Shadow only changes at the boundary, so this mask is effectively frame-latched.
    assign zero3   = (shadow_d[15:12] == 4'd0);
    assign zero32  = zero3 && (shadow_d[11:8] == 4'd0);
    assign zero321 = zero32 && (shadow_d[7:4] == 4'd0);
    assign blank_d = {zero3, zero32, zero321, 1'b0};
    assign lit_d   = nib_ok_d && !blank_d[idx_d];
`else
    assign lit_d = nib_ok_d;
`endif

    always_comb begin
        an_d  = 4'b1111;
        bcd_d = bcd_q;
        if (state_d == StShow) begin
            bcd_d = nib_ok_d ? nib_d : 4'd0;
            if (lit_d) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StShow;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            staging_q    <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            run_q        <= 1'b0;
            an_q         <= 4'b1111;
            bcd_q        <= 4'd0;
            frame_tick_q <= 1'b0;
            upd_ack_q    <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
            frame_tick_q <= boundary;
            upd_ack_q    <= commit;
            if (load && !boundary) begin
                staging_q <= digits_in;
            end
            pending_q <= boundary ? 1'b0 : (pending_q || load);
        end
    end

    assign an         = an_q;
    assign digit_bcd  = bcd_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;
    assign upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed vector table, hand-written reset sequence,
// and randomized loads checked against a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned RefreshDiv  = 4;
    localparam int unsigned GapCycles   = 1;
    localparam int          DigitPeriod = RefreshDiv + GapCycles;
    localparam int          FramePeriod = 4 * DigitPeriod;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  an;
    logic [3:0]  digit_bcd;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        upd_ack;

    seg_scan_ctrl #(
        .REFRESH_DIV (RefreshDiv),
        .GAP_CYCLES  (GapCycles)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .an         (an),
        .digit_bcd  (digit_bcd),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick),
        .upd_ack    (upd_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] din;
        logic [3:0]  an;
        logic [3:0]  bcd;
        logic [1:0]  idx;
        logic        tick;
        logic        ack;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passed = 0;
    int t = 0;

    // Reference model state: displayed frame, staged frame, pending flag, ack expectation.
    logic [15:0] m_disp, m_stage, m_tmp, r_din;
    logic        m_pend, m_ack, r_ld, m_show, m_ok;
    logic [3:0]  m_nib, m_onehot, e_an, e_bcd;
    int          p, k;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at t=%0d: actual %h, required %h", name, t, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [3:0] e_a, input logic [3:0] e_b,
                           input logic [1:0] e_i, input logic e_t, input logic e_k);
        chk({name, ".an"}, {12'h0, an}, {12'h0, e_a});
        chk({name, ".bcd"}, {12'h0, digit_bcd}, {12'h0, e_b});
        chk({name, ".idx"}, {14'h0, digit_idx}, {14'h0, e_i});
        chk({name, ".tick"}, {15'h0, frame_tick}, {15'h0, e_t});
        chk({name, ".ack"}, {15'h0, upd_ack}, {15'h0, e_k});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Leaves the bench at cycle 0: the first cycle digit 0 is lit.
    task automatic do_reset();
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 4'b1111, 4'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t = 0;
    endtask

    function automatic logic blanked(input logic [15:0] d, input int dig);
`ifdef SEG_SCAN_LZB_EN
        case (dig)
            3:       return d[15:12] == 4'd0;
            2:       return d[15:8] == 8'd0;
            1:       return d[15:4] == 12'd0;
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t v(input int c, input logic l, input logic [15:0] d,
                               input logic [3:0] a, input logic [3:0] b, input logic [1:0] x,
                               input logic tk, input logic ak);
        vec_t r;
        r.cyc = c; r.ld = l; r.din = d; r.an = a; r.bcd = b; r.idx = x; r.tick = tk; r.ack = ak;
        return r;
    endfunction

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 11) == 0) f[4*i +: 4] = 4'($urandom_range(10, 15));
            else if ($urandom_range(0, 2) == 0) f[4*i +: 4] = 4'd0;
            else f[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return f;
    endfunction

    initial begin
`ifndef SEG_SCAN_LZB_EN
        vecs.push_back(v(  0, 0, 16'h0000, 4'b1110, 4'd0, 2'd0, 0, 0));
        vecs.push_back(v(  3, 0, 16'h0000, 4'b1110, 4'd0, 2'd0, 0, 0));
        vecs.push_back(v(  4, 0, 16'h0000, 4'b1111, 4'd0, 2'd0, 0, 0));
        vecs.push_back(v(  5, 0, 16'h0000, 4'b1101, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(  7, 1, 16'h1234, 4'b1101, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(  9, 0, 16'h0000, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v( 10, 0, 16'h0000, 4'b1011, 4'd0, 2'd2, 0, 0));
        vecs.push_back(v( 15, 0, 16'h0000, 4'b0111, 4'd0, 2'd3, 0, 0));
        vecs.push_back(v( 19, 0, 16'h0000, 4'b1111, 4'd0, 2'd3, 0, 0));
        vecs.push_back(v( 20, 0, 16'h0000, 4'b1110, 4'd4, 2'd0, 1, 1));
        vecs.push_back(v( 21, 0, 16'h0000, 4'b1110, 4'd4, 2'd0, 0, 0));
        vecs.push_back(v( 25, 0, 16'h0000, 4'b1101, 4'd3, 2'd1, 0, 0));
        vecs.push_back(v( 30, 0, 16'h0000, 4'b1011, 4'd2, 2'd2, 0, 0));
        vecs.push_back(v( 35, 0, 16'h0000, 4'b0111, 4'd1, 2'd3, 0, 0));
        vecs.push_back(v( 40, 0, 16'h0000, 4'b1110, 4'd4, 2'd0, 1, 0));
        vecs.push_back(v( 42, 1, 16'h1111, 4'b1110, 4'd4, 2'd0, 0, 0));
        vecs.push_back(v( 50, 1, 16'h5678, 4'b1011, 4'd2, 2'd2, 0, 0));
        vecs.push_back(v( 59, 0, 16'h0000, 4'b1111, 4'd1, 2'd3, 0, 0));
        vecs.push_back(v( 60, 0, 16'h0000, 4'b1110, 4'd8, 2'd0, 1, 1));
        vecs.push_back(v( 61, 0, 16'h0000, 4'b1110, 4'd8, 2'd0, 0, 0));
        vecs.push_back(v( 65, 0, 16'h0000, 4'b1101, 4'd7, 2'd1, 0, 0));
        vecs.push_back(v( 70, 0, 16'h0000, 4'b1011, 4'd6, 2'd2, 0, 0));
        vecs.push_back(v( 75, 0, 16'h0000, 4'b0111, 4'd5, 2'd3, 0, 0));
        vecs.push_back(v( 79, 1, 16'h0909, 4'b1111, 4'd5, 2'd3, 0, 0));
        vecs.push_back(v( 80, 0, 16'h0000, 4'b1110, 4'd9, 2'd0, 1, 1));
        vecs.push_back(v( 85, 0, 16'h0000, 4'b1101, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v( 90, 0, 16'h0000, 4'b1011, 4'd9, 2'd2, 0, 0));
        vecs.push_back(v( 95, 0, 16'h0000, 4'b0111, 4'd0, 2'd3, 0, 0));
        vecs.push_back(v(100, 0, 16'h0000, 4'b1110, 4'd9, 2'd0, 1, 0));
        vecs.push_back(v(101, 1, 16'h12A4, 4'b1110, 4'd9, 2'd0, 0, 0));
        vecs.push_back(v(120, 0, 16'h0000, 4'b1110, 4'd4, 2'd0, 1, 1));
        vecs.push_back(v(125, 0, 16'h0000, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(126, 0, 16'h0000, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(129, 0, 16'h0000, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(130, 0, 16'h0000, 4'b1011, 4'd2, 2'd2, 0, 0));
        vecs.push_back(v(135, 0, 16'h0000, 4'b0111, 4'd1, 2'd3, 0, 0));
`else
        vecs.push_back(v(  0, 0, 16'h0000, 4'b1110, 4'd0, 2'd0, 0, 0));
        vecs.push_back(v(  5, 0, 16'h0000, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v(  7, 1, 16'h0042, 4'b1111, 4'd0, 2'd1, 0, 0));
        vecs.push_back(v( 20, 0, 16'h0000, 4'b1110, 4'd2, 2'd0, 1, 1));
        vecs.push_back(v( 25, 0, 16'h0000, 4'b1101, 4'd4, 2'd1, 0, 0));
        vecs.push_back(v( 30, 0, 16'h0000, 4'b1111, 4'd0, 2'd2, 0, 0));
        vecs.push_back(v( 35, 0, 16'h0000, 4'b1111, 4'd0, 2'd3, 0, 0));
`endif

        // Directed vectors.
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            while (t < vecs[i].cyc) begin
                load = 1'b0;
                next_cycle();
            end
            chk_all($sformatf("vec%0d", i), vecs[i].an, vecs[i].bcd, vecs[i].idx,
                    vecs[i].tick, vecs[i].ack);
            load      = vecs[i].ld;
            digits_in = vecs[i].din;
            next_cycle();
            load = 1'b0;
        end

        // Reset mid-frame with a pending load and a same-cycle load: both discarded.
        do_reset();
        while (t < 7) next_cycle();
        load      = 1'b1;
        digits_in = 16'h1234;
        next_cycle();
        load = 1'b0;
        while (t < 13) next_cycle();
        rst       = 1'b1;
        load      = 1'b1;
        digits_in = 16'h9999;
        next_cycle();
        chk_all("midrst", 4'b1111, 4'd0, 2'd0, 1'b0, 1'b0);
        rst  = 1'b0;
        load = 1'b0;
        next_cycle();
        t = 0;
        chk("midrst.restart_an", {12'h0, an}, {12'h0, blanked(16'h0, 0) ? 4'b1111 : 4'b1110});
        while (t < FramePeriod) begin
            next_cycle();
            chk("midrst.no_ack", {15'h0, upd_ack}, 16'h0);
        end
        chk("midrst.tick", {15'h0, frame_tick}, 16'h1);
        chk("midrst.bcd", {12'h0, digit_bcd}, 16'h0);

        // Randomized loads against the frame-level model.
        do_reset();
        m_disp  = 16'h0000;
        m_stage = 16'h0000;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            p        = t % FramePeriod;
            k        = p / DigitPeriod;
            m_show   = (p % DigitPeriod) < RefreshDiv;
            m_tmp    = m_disp >> (4 * k);
            m_nib    = m_tmp[3:0];
            m_ok     = m_nib <= 4'd9;
            m_onehot = 4'b0001 << k;
            e_an     = (m_show && m_ok && !blanked(m_disp, k)) ? ~m_onehot : 4'b1111;
            e_bcd    = m_ok ? m_nib : 4'd0;
            chk_all("rand", e_an, e_bcd, 2'(k), (t > 0) && (p == 0), m_ack);

            r_ld  = (p == FramePeriod - 1) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 7) == 0);
            r_din = rand_frame();
            load      = r_ld;
            digits_in = r_din;
            if (p == FramePeriod - 1) begin
                if (r_ld) begin
                    m_disp = r_din;
                    m_pend = 1'b0;
                    m_ack  = 1'b1;
                end else if (m_pend) begin
                    m_disp = m_stage;
                    m_pend = 1'b0;
                    m_ack  = 1'b1;
                end else begin
                    m_ack = 1'b0;
                end
            end else begin
                m_ack = 1'b0;
                if (r_ld) begin
                    m_stage = r_din;
                    m_pend  = 1'b1;
                end
            end
            next_cycle();
            load = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the digital clock's 4-digit common-anode 7-segment display. It holds a committed 4-digit BCD frame and steps through the digits, presenting one BCD nibble at a time to the shared BCD-to-segment decoder while driving the matching active-low digit enable. Frame updates are tear-free: new digits commit only at a frame boundary. A blanking gap between digits prevents ghosting.

## Interface
- `REFRESH_DIV`, 50000: clk cycles each digit is lit (SHOW phase); legal range ≥1.
- `GAP_CYCLES`, 500: clk cycles all digits are dark between digits (GAP phase); legal range ≥1.
- `clk`  in  1  system clock, sole clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `digits_in`  in  16  BCD frame; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- `load`  in  1  single-cycle strobe; captures `digits_in` into staging.
- `an`  out  4  active-low digit enables; bit k lights digit k.
- `digit_bcd`  out  4  BCD nibble of the currently selected digit, to the decoder `in`.
- `digit_idx`  out  2  index of the currently selected digit.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.
- `upd_ack`  out  1  one-cycle pulse when a pending load commits.

## Operation
- Registers: `staging[15:0]`, `shadow[15:0]` (displayed frame), `pending`, `idx[1:0]`, `cnt`, and a state bit that is either SHOW or GAP.
- SHOW: `an` = ~(1<<idx), `digit_bcd` = shadow nibble idx. Stay until `cnt` == REFRESH_DIV-1, then go to GAP with `cnt` cleared.
- GAP: `an` = 4'b1111, `digit_bcd` holds. Stay until `cnt` == GAP_CYCLES-1, then go to SHOW with `cnt` cleared and idx+1. idx wraps from 3 to 0.
- Frame boundary: the GAP→SHOW transition where idx wraps from 3 to 0.
  - `frame_tick` is 1 on the cycle after this edge.
  - If `pending` is set, `shadow` ← `staging`, `pending` clears and `upd_ack` is 1 for one cycle, aligned with `frame_tick`.
- `load` sets `staging` ← `digits_in` and sets `pending`.
- Repeated loads within a frame: last one wins, with a single `upd_ack`.
- `load` on the boundary cycle: `digits_in` bypasses `staging` and commits directly; `pending` ends clear.
- Invalid nibble (>9) in `shadow`: that digit's `an` stays 4'b1111 during its SHOW, and `digit_bcd` is forced to 0. The decoder has no default case, so it must never see a value >9.

## Timing
- Reset values: `an`=4'b1111, `digit_bcd`=0, `digit_idx`=0, `frame_tick`=0, `upd_ack`=0. Internally `shadow`=0, `staging`=0, `pending`=0, `cnt`=0, state=SHOW.
- First SHOW of digit 0 begins the cycle after `rst` deasserts.
- All outputs are registered. `an`, `digit_bcd` and `digit_idx` change on the same edge as the state transition.
- Digit period = REFRESH_DIV + GAP_CYCLES. Frame period = 4 × (REFRESH_DIV + GAP_CYCLES).
- Load-to-display latency: at most one frame plus one cycle.
- `rst` mid-frame: takes priority over every event in the same cycle, including `load` and the boundary. The pending update is discarded.
- `cnt` width is clog2(max(REFRESH_DIV, GAP_CYCLES)). It never exceeds its terminal value.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking. At the frame boundary, compute a mask from the newly committed `shadow`:
  - digit 3 is blanked if its nibble is 0;
  - digit 2 is blanked if its nibble and digit 3's are both 0;
  - digit 1 is blanked if digits 3..1 are all 0;
  - digit 0 is never blanked.
  - Blanked digits keep `an` = 4'b1111 during SHOW; timing is unchanged.
- `SEG_SCAN_LZB_EN` undefined: all valid digits are shown, including leading zeros. No mask logic is built.

## Test plan
- Reset then run, with REFRESH_DIV=4, GAP_CYCLES=1 and shadow=0: `an` goes 1110 (4 cycles), 1111 (1), 1101 (4), 1111 (1), 1011, …; `frame_tick` pulses every 20 cycles.
- Load mid-frame, `digits_in`=16'h1234 on cycle 7: display is unchanged until the boundary; `upd_ack` and `frame_tick` pulse together at cycle 20; the next frame shows `digit_bcd` 4, 3, 2, 1.
- Two loads in one frame, 16'h1111 then 16'h5678: exactly one `upd_ack`; displayed frame is 16'h5678.
- `load` of 16'h0909 on the boundary cycle: it commits immediately; the following frame shows 9, 0, 9, 0 with no extra frame of delay.
- Invalid nibble, 16'h12A4: digit 1 stays dark (`an`=1111) with `digit_bcd`=0 during its SHOW; the other digits are normal.
- `rst` asserted at cycle 13 with a pending load: outputs return to reset values the next cycle; no `upd_ack`. With `SEG_SCAN_LZB_EN` defined, load 16'h0042: digits 3 and 2 stay dark.
